// File: rtl/dm_pkg.sv
// dm_pkg: shared debug-module types and constants for the SBA AXI4-Lite bridge
package dm_pkg;

  typedef enum logic [2:0] {
    SBA_IDLE,
    SBA_WR_REQ,
    SBA_WR_RESP,
    SBA_RD_REQ,
    SBA_RD_RESP,
    SBA_DONE
  } sba_axil_state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // unprivileged, non-secure, data access
  localparam logic [2:0] AXI_PROT = 3'b010;

  function automatic logic axi_resp_err(input logic [1:0] resp);
    return (resp == AXI_SLVERR) || (resp == AXI_DECERR);
  endfunction

endpackage

// File: rtl/dm_sba_axil_bridge.sv
// dm_sba_axil_bridge: single-outstanding SBA req/gnt/r_valid to AXI4-Lite master
module dm_sba_axil_bridge
  import dm_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [BusWidth-1:0]   add_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [BusWidth/8-1:0] be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [BusWidth-1:0]   r_rdata_o,
  output logic                  r_err_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [BusWidth-1:0]   m_awaddr_o,
  output logic [2:0]            m_awprot_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  output logic [BusWidth-1:0]   m_wdata_o,
  output logic [BusWidth/8-1:0] m_wstrb_o,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  input  logic [1:0]            m_bresp_i,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [BusWidth-1:0]   m_araddr_o,
  output logic [2:0]            m_arprot_o,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [BusWidth-1:0]   m_rdata_i,
  input  logic [1:0]            m_rresp_i
);

  sba_axil_state_e       state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [BusWidth-1:0]   addr_q, addr_d;
  logic [BusWidth-1:0]   wdata_q, wdata_d;
  logic [BusWidth/8-1:0] strb_q, strb_d;
  logic [BusWidth-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;

  // state and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SBA_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // next state, request capture, AW/W completion tracking and response latching
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      SBA_IDLE: if (req_i) begin
        state_d = we_i ? SBA_WR_REQ : SBA_RD_REQ;
        addr_d  = add_i;
        wdata_d = wdata_i;
        strb_d  = be_i;
      end
      SBA_WR_REQ: begin
        aw_done_d = aw_done_q | m_awready_i;
        w_done_d  = w_done_q | m_wready_i;
        if (aw_done_d && w_done_d) begin
          state_d   = SBA_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      SBA_WR_RESP: if (m_bvalid_i) begin
        state_d = SBA_DONE;
        rdata_d = '0;
        err_d   = axi_resp_err(m_bresp_i);
      end
      SBA_RD_REQ: if (m_arready_i) state_d = SBA_RD_RESP;
      SBA_RD_RESP: if (m_rvalid_i) begin
        state_d = SBA_DONE;
        rdata_d = m_rdata_i;
        err_d   = axi_resp_err(m_rresp_i);
      end
      default: state_d = SBA_IDLE;
    endcase
  end

  // outputs are pure functions of registered state so no valid depends on a ready
  always_comb begin
    gnt_o       = (state_q == SBA_IDLE) && req_i;
    r_valid_o   = state_q == SBA_DONE;
    r_rdata_o   = rdata_q;
    r_err_o     = err_q;
    m_awvalid_o = (state_q == SBA_WR_REQ) && !aw_done_q;
    m_wvalid_o  = (state_q == SBA_WR_REQ) && !w_done_q;
    m_bready_o  = state_q == SBA_WR_RESP;
    m_arvalid_o = state_q == SBA_RD_REQ;
    m_rready_o  = state_q == SBA_RD_RESP;
    m_awaddr_o  = addr_q;
    m_araddr_o  = addr_q;
    m_wdata_o   = wdata_q;
    m_wstrb_o   = strb_q;
    m_awprot_o  = AXI_PROT;
    m_arprot_o  = AXI_PROT;
  end

endmodule

// File: doc/dm_sba_axil_bridge.md
Name: dm_sba_axil_bridge

Overview:
Downstream stage of the debug-module system bus access (SBA) master. It converts the SBA req/gnt/r_valid memory port into a single-outstanding AXI4-Lite master. The debugger's bus transactions reach the SoC interconnect through this block. Every accepted request, read or write, completes with exactly one r_valid_o pulse, and that pulse carries the response error flag.

Parameters:
BusWidth, 32, address and data width in bits (32 or 64); strobe width is BusWidth/8

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  1  SBA request; held high until gnt_o
add_i  in  BusWidth  SBA byte address
we_i  in  1  1 = write, 0 = read
wdata_i  in  BusWidth  write data
be_i  in  BusWidth/8  byte enables
gnt_o  out  1  request accepted (combinational)
r_valid_o  out  1  completion pulse, one cycle, for reads and writes
r_rdata_o  out  BusWidth  read data; 0 on write completion
r_err_o  out  1  completion had SLVERR/DECERR; valid with r_valid_o
m_awvalid_o / m_awready_i / m_awaddr_o[BusWidth] / m_awprot_o[3]  AXI write address channel
m_wvalid_o / m_wready_i / m_wdata_o[BusWidth] / m_wstrb_o[BusWidth/8]  AXI write data channel
m_bvalid_i / m_bready_o / m_bresp_i[2]  AXI write response channel
m_arvalid_o / m_arready_i / m_araddr_o[BusWidth] / m_arprot_o[3]  AXI read address channel
m_rvalid_i / m_rready_o / m_rdata_i[BusWidth] / m_rresp_i[2]  AXI read data channel

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state Idle.
  - All AXI valid/ready outputs 0.
  - r_valid_o=0, r_err_o=0, r_rdata_o=0.
  - Address/data/strobe registers 0.
- Reset mid-transaction: abandon immediately and return to Idle. The interconnect shares this reset, so no drain is performed.
- prot fields are constant 3'b010 (unprivileged, non-secure, data).
- FSM states: Idle, WrReq, WrResp, RdReq, RdResp, Done.
- Idle:
  - gnt_o = req_i, combinationally, only in Idle; gnt_o=0 in every other state.
  - On req_i, capture add_i, wdata_i, be_i.
  - we_i=1 -> WrReq. we_i=0 -> RdReq.
- WrReq:
  - awvalid and wvalid assert from the first cycle after grant.
  - Each channel deasserts independently on its own handshake, tracked by aw_done and w_done flags. Same-cycle and either-order handshakes are legal.
  - When both are done -> WrResp; clear both flags.
- WrResp:
  - m_bready_o=1.
  - On bvalid, latch err = bresp[1] and rdata = 0, then -> Done.
- RdReq:
  - arvalid asserts; on arready -> RdResp.
- RdResp:
  - m_rready_o=1.
  - On rvalid, latch rdata = m_rdata_i and err = rresp[1], then -> Done.
- Done:
  - r_valid_o=1 for exactly one cycle with the latched r_rdata_o and r_err_o, then -> Idle.
  - r_rdata_o and r_err_o hold their values until the next completion.
- Outputs are stable while valid is high, per AXI. No AXI valid depends combinationally on any ready.
- Latency with zero-wait-state slave:
  - read: grant cycle 0, AR handshake cycle 1, R handshake cycle 2, r_valid_o cycle 3.
  - write: r_valid_o in the same cycle 3.
- Exactly one outstanding transaction. A new grant is possible in the cycle after Done at the earliest (Idle).
- No address alignment checks or size splitting: the upstream SBA master guarantees legal strobes.
- OKAY and EXOKAY both give r_err_o=0.

Decomposition:
- Shared debug package (dm_pkg) gains:
  - the bridge state enum;
  - AXI resp localparams: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the fixed PROT constant.
- No sub-module: the AW/W completion flags are two flops and stay inline.

Test Plan:
- Read, zero-wait slave: req add=0x1000 we=0, slave returns rdata=0xDEADBEEF OKAY -> gnt same cycle; araddr=0x1000; r_valid_o at cycle 3 with rdata=0xDEADBEEF, err=0.
- Write with reordered channels: be=4'b0011, wdata=0x0000ABCD; slave takes W 2 cycles before AW -> wvalid drops after its handshake while awvalid stays high; wstrb=0011; bresp=OKAY; one r_valid_o with rdata=0, err=0.
- Error responses: read answered DECERR -> r_err_o=1; then write answered SLVERR -> r_err_o=1; then read answered OKAY -> r_err_o=0.
- Backpressure: arready held low 5 cycles -> araddr stable, arvalid high throughout, gnt_o=0; req_i asserted during busy gets no grant until Idle.
- Reset mid-transaction: rst_i pulsed in WrResp -> all valids and readies 0 asynchronously; next req granted in Idle with no spurious r_valid_o.
- BusWidth=64: add=0x...08, be=8'hF0, write -> wstrb=8'hF0; read data 64-bit round-trips intact.
